// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB result bus carrying one instruction's writeback fields
//   master: MEM stage side, drives every field
//   slave : writeback stage side, samples every field
interface wb_stage_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_reg_wr;
  logic [AW-1:0] in_rd;
  logic [1:0]    in_wb_sel;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_pc_plus4;
  logic [DW-1:0] in_load_data;
  logic [2:0]    in_load_funct3;
  logic [1:0]    in_byte_off;
  modport master (
    output in_valid, in_reg_wr, in_rd, in_wb_sel, in_alu_result,
           in_pc_plus4, in_load_data, in_load_funct3, in_byte_off
  );
  modport slave (
    input in_valid, in_reg_wr, in_rd, in_wb_sel, in_alu_result,
          in_pc_plus4, in_load_data, in_load_funct3, in_byte_off
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: RISC-V writeback stage with MEM/WB register, load formatting, forwarding and instret
//   clk, rst_n (sync, active-low), stall (hold entry), flush (invalidate entry)
//   mem         : MEM-stage result bus (slave side)
//   rf_wr_*     : register-file write port, one cycle after capture
//   fwd_*       : copy of the write port for upstream bypassing
//   load_err    : misaligned or illegal load in the stage
//   instret     : 64-bit retired-instruction count
module wb_stage #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  wb_stage_if.slave     mem,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic          load_err,
  output logic [63:0]   instret
);
  logic          valid_q, reg_wr_q;
  logic [AW-1:0] rd_q;
  logic [1:0]    wb_sel_q, off_q;
  logic [DW-1:0] alu_q, pc4_q, ld_q;
  logic [2:0]    f3_q;
  logic [63:0]   instret_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      rd_q      <= '0;
      wb_sel_q  <= '0;
      alu_q     <= '0;
      pc4_q     <= '0;
      ld_q      <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      instret_q <= '0;
    end else begin
      if (flush) valid_q <= 1'b0;
      else if (!stall) begin
        valid_q  <= mem.in_valid;
        reg_wr_q <= mem.in_reg_wr;
        rd_q     <= mem.in_rd;
        wb_sel_q <= mem.in_wb_sel;
        alu_q    <= mem.in_alu_result;
        pc4_q    <= mem.in_pc_plus4;
        ld_q     <= mem.in_load_data;
        f3_q     <= mem.in_load_funct3;
        off_q    <= mem.in_byte_off;
      end
      // an entry retires only on the edge where it leaves the stage unflushed
      if (valid_q && !stall && !flush) instret_q <= instret_q + 64'd1;
    end
  end
  logic [7:0]    b;
  logic [15:0]   h;
  logic          sx, misal, illegal;
  logic [DW-1:0] fmt;
  always_comb begin
    b       = ld_q[{off_q, 3'b000} +: 8];
    h       = ld_q[{off_q[1], 4'b0000} +: 16];
    sx      = ~f3_q[2];
    illegal = f3_q == 3'b011 || f3_q[2:1] == 2'b11;
    misal   = (f3_q[1:0] == 2'b01 && off_q[0]) || (f3_q[1:0] == 2'b10 && off_q != 2'b00);
    fmt     = f3_q[1:0] == 2'b00 ? {{(DW-8){sx & b[7]}}, b} :
              f3_q[1:0] == 2'b01 ? {{(DW-16){sx & h[15]}}, h} : ld_q;
    load_err   = valid_q && wb_sel_q == 2'b01 && (misal || illegal);
    rf_wr_data = load_err            ? '0    :
                 wb_sel_q == 2'b00   ? alu_q :
                 wb_sel_q == 2'b01   ? fmt   :
                 wb_sel_q == 2'b10   ? pc4_q : '0;
    rf_wr_en   = valid_q && reg_wr_q && rd_q != '0 && !load_err && wb_sel_q != 2'b11;
    rf_wr_addr = rd_q;
    fwd_valid  = rf_wr_en;
    fwd_rd     = rf_wr_addr;
    fwd_data   = rf_wr_data;
    instret    = instret_q;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) pipeline stage of the RISC-V core; consumes MEM-stage results and produces the register-file write port (wr_en/wr_addr/wr_data).
- Holds the MEM/WB pipeline register and selects the writeback source: ALU result, formatted load data, or PC+4.
- Formats loads (LB/LH/LW/LBU/LHU) from the raw memory word and byte offset.
- Exports forwarding info for upstream bypass logic and maintains a 64-bit retired-instruction counter.

Parameters:
AW, 5, register address width; must match register-file AW
DW, 32, data width; fixed at 32 for RV32 load formatting

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset
stall  input  1  hold the pipeline register contents
flush  input  1  invalidate the captured entry
in_valid  input  1  MEM stage presents a valid instruction
in_reg_wr  input  1  instruction writes rd
in_rd  input  AW  destination register
in_wb_sel  input  2  00 = ALU, 01 = load, 10 = PC+4, 11 = reserved
in_alu_result  input  DW  ALU result
in_pc_plus4  input  DW  link value
in_load_data  input  DW  raw aligned memory word
in_load_funct3  input  3  load type
in_byte_off  input  2  address bits [1:0] of the load
rf_wr_en  output  1  register-file write enable
rf_wr_addr  output  AW  register-file write address
rf_wr_data  output  DW  register-file write data
fwd_valid  output  1  forwarding data valid; equals rf_wr_en
fwd_rd  output  AW  forwarded register; equals rf_wr_addr
fwd_data  output  DW  forwarded data; equals rf_wr_data
load_err  output  1  misaligned or illegal load in the stage
instret  output  64  retired-instruction count

Behaviour:
- Reset (rst_n = 0 at posedge): clear all pipeline fields, valid, and instret. Outputs then read rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0, fwd_* = 0, load_err = 0, instret = 0.
- Capture priority at each posedge: reset > flush > stall > load.
  - flush: valid_q <= 0; other fields are don't-care.
  - stall: all fields hold.
  - otherwise: every in_* field is registered, with valid_q <= in_valid.
- Latency: one cycle from an input at a posedge to the register-file write.
  - All outputs are combinational from registered state only; there is no combinational path from any in_* port.
- Write enable:
  - rf_wr_en = valid_q & reg_wr_q & (rd_q != 0) & !load_err. Writes to x0 are always suppressed.
  - During a stall the same entry is presented again each cycle. The repeated write is idempotent and is permitted.
- Data select:
  - wb_sel 00 → alu_q.
  - wb_sel 10 → pc4_q.
  - wb_sel 01 → formatted load.
  - wb_sel 11 → data 0 and write suppressed.
- Load formatting (wb_sel = 01):
  - LB 000: byte lane = off, sign-extended.
  - LBU 100: byte lane = off, zero-extended.
  - LH 101/001: half lane = off[1]; off[0] = 1 is misaligned. LH sign-extends, LHU zero-extends.
  - LW 010: off must be 00, otherwise misaligned.
  - funct3 011/110/111 is illegal.
- load_err: = valid_q & (wb_sel_q = 01) & (misaligned | illegal). When asserted, data is 0 and the write is suppressed.
- instret:
  - Increments by 1 at a posedge when the stage leaves a valid entry, i.e. valid_q & !stall & !flush. Each retired instruction counts exactly once, regardless of stall length.
  - Flushed entries are not counted.
  - Wraps modulo 2^64.
- Reset mid-stall or mid-flush: reset wins; state is cleared the same cycle.
- Flush and stall together: flush wins.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 → rf_wr_en = 0, instret = 0, all outputs 0 after reset.
- ALU writeback: in_rd = 5, wb_sel = 00, alu = 0xDEADBEEF, reg_wr = 1 → next cycle rf_wr_en = 1, addr = 5, data = 0xDEADBEEF, fwd_* identical. Repeat with rd = 0 → rf_wr_en = 0.
- Loads on word 0x80F0_7F01:
  - LB off = 3 → 0xFFFFFF80
  - LBU off = 3 → 0x00000080
  - LH off = 2 → 0xFFFF80F0
  - LHU off = 0 → 0x00007F01
  - LW off = 0 → 0x80F07F01
- Errors: LH off = 1, LW off = 2, funct3 = 011 → load_err = 1, rf_wr_en = 0, data = 0.
- Stall and flush: capture a JAL (wb_sel = 10, pc4 = 0x104, rd = 1), then stall 3 cycles → write of 0x104 presented 4 cycles; instret increments by 1 only, when the entry leaves. Then flush with in_valid = 1 → rf_wr_en = 0 next cycle and instret unchanged.
- Simultaneous events: flush = 1 and stall = 1 together → entry invalidated. rst_n = 0 during a stall → everything cleared on that edge.
